// File: rtl/bit_serializer.sv
// ============================================================================
// Module   : bit_serializer
// Brief    : WIDTH-bit parallel word to MSB-first serial stream, DIV clocks
//            per bit, early ready for gapless back-to-back words.
//            Optional even-parity bit: define SER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             last
);

  localparam int c_IW = $clog2(WIDTH + 1);
  localparam int c_DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_IW-1:0] c_BIT_MAX = c_IW'(WIDTH - 1);
  localparam logic [c_DW-1:0] c_DIV_MAX = c_DW'(DIV - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SHIFT = 2'd1;
`ifdef SER_PARITY_EN
  localparam logic [1:0] c_ST_PAR   = 2'd2;
`endif

  logic [1:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [c_IW-1:0]  r_bidx,  w_bidx_nxt;
  logic [c_DW-1:0]  r_div,   w_div_nxt;
`ifdef SER_PARITY_EN
  logic             r_par,   w_par_nxt;
`endif

  logic r_bit_out, r_bit_valid, r_busy, r_last;
  logic w_bit_out_nxt, w_last_nxt, w_busy_nxt;
  logic w_div_end, w_bit_end, w_word_end, w_accept, w_load;

  assign w_div_end = (r_div == c_DIV_MAX);
  assign w_bit_end = (r_bidx == c_BIT_MAX);

  // Word ends on the final divider cycle of the last bit (parity or LSB)
`ifdef SER_PARITY_EN
  assign w_word_end = (r_state == c_ST_PAR) && w_div_end;
`else
  assign w_word_end = (r_state == c_ST_SHIFT) && w_bit_end && w_div_end;
`endif

  assign din_ready = (r_state == c_ST_IDLE) || w_word_end;
  assign w_accept  = din_valid && din_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bidx_nxt  = r_bidx;
    w_div_nxt   = r_div;
`ifdef SER_PARITY_EN
    w_par_nxt   = r_par;
`endif
    w_load      = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_load = w_accept;
      end
      c_ST_SHIFT: begin
        if (w_div_end) begin
          w_div_nxt = '0;
          if (w_bit_end) begin
            w_bidx_nxt = '0;
`ifdef SER_PARITY_EN
            w_state_nxt = c_ST_PAR;
`else
            w_state_nxt = c_ST_IDLE;
            w_load      = w_accept;
`endif
          end else begin
            w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
            w_bidx_nxt  = r_bidx + c_IW'(1);
          end
        end else begin
          w_div_nxt = r_div + c_DW'(1);
        end
      end
`ifdef SER_PARITY_EN
      c_ST_PAR: begin
        if (w_div_end) begin
          w_div_nxt   = '0;
          w_state_nxt = c_ST_IDLE;
          w_load      = w_accept;
        end else begin
          w_div_nxt = r_div + c_DW'(1);
        end
      end
`endif
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
    // A reload overrides the return to IDLE so back-to-back words have no gap
    if (w_load) begin
      w_state_nxt = c_ST_SHIFT;
      w_shreg_nxt = din;
      w_bidx_nxt  = '0;
      w_div_nxt   = '0;
`ifdef SER_PARITY_EN
      w_par_nxt   = ^din;
`endif
    end
  end

  always_comb begin
    w_busy_nxt    = (w_state_nxt != c_ST_IDLE);
    w_bit_out_nxt = 1'b1;
    if (w_state_nxt == c_ST_SHIFT) begin
      w_bit_out_nxt = w_shreg_nxt[WIDTH-1];
    end
`ifdef SER_PARITY_EN
    if (w_state_nxt == c_ST_PAR) begin
      w_bit_out_nxt = w_par_nxt;
    end
    w_last_nxt = (w_state_nxt == c_ST_PAR);
`else
    w_last_nxt = (w_state_nxt == c_ST_SHIFT) && (w_bidx_nxt == c_BIT_MAX);
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= c_ST_IDLE;
      r_shreg     <= '0;
      r_bidx      <= '0;
      r_div       <= '0;
`ifdef SER_PARITY_EN
      r_par       <= 1'b0;
`endif
      r_bit_out   <= 1'b1;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_bidx      <= w_bidx_nxt;
      r_div       <= w_div_nxt;
`ifdef SER_PARITY_EN
      r_par       <= w_par_nxt;
`endif
      r_bit_out   <= w_bit_out_nxt;
      r_bit_valid <= w_busy_nxt && (w_div_nxt == '0);
      r_busy      <= w_busy_nxt;
      r_last      <= w_last_nxt;
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign busy      = r_busy;
  assign last      = r_last;

endmodule

`default_nettype wire
